// File: rtl/onewire_byte_master_if.sv
// Command/response port of the 1-Wire byte master.
// The host drives the command side through master. The engine uses slave.
interface onewire_byte_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       crc_clr;
  logic       rsp_valid;
  logic [7:0] rdata;
  logic       presence;
  logic [7:0] crc;
  logic       busy;

  modport master (
    output cmd_valid, cmd, wdata, crc_clr,
    input  cmd_ready, rsp_valid, rdata, presence, crc, busy
  );

  modport slave (
    input  cmd_valid, cmd, wdata, crc_clr,
    output cmd_ready, rsp_valid, rdata, presence, crc, busy
  );
endinterface

// File: rtl/onewire_byte_master.sv
// 1-Wire bus master engine: reset/presence, write byte and read byte commands,
// with open-drain DQ drive and a Dallas CRC-8 over every sampled bit.
module onewire_byte_master #(
  parameter int unsigned T_RSTL = 48000,
  parameter int unsigned T_RSTH = 48000,
  parameter int unsigned T_MSP  = 7000,
  parameter int unsigned T_LOW0 = 6000,
  parameter int unsigned T_LOW1 = 600,
  parameter int unsigned T_MSR  = 1300,
  parameter int unsigned T_SLOT = 7000,
  parameter int unsigned T_REC  = 500
) (
  input  logic                 clk,
  input  logic                 reset,
  onewire_byte_master_if.slave bus,
  inout  wire                  port
);
  localparam int unsigned T_BIT = T_SLOT + T_REC;
  localparam int unsigned T_RMX = (T_RSTL > T_RSTH) ? T_RSTL : T_RSTH;
  localparam int unsigned T_MAX = (T_RMX > T_BIT) ? T_RMX : T_BIT;
  localparam int          CW    = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] C_RSTL_END = CW'(T_RSTL - 1);
  localparam logic [CW-1:0] C_RSTH_END = CW'(T_RSTH - 1);
  localparam logic [CW-1:0] C_MSP      = CW'(T_MSP);
  localparam logic [CW-1:0] C_MSR      = CW'(T_MSR);
  localparam logic [CW-1:0] C_LOW0     = CW'(T_LOW0);
  localparam logic [CW-1:0] C_LOW1     = CW'(T_LOW1);
  localparam logic [CW-1:0] C_BIT_END  = CW'(T_BIT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RST_LOW = 3'd1;
  localparam logic [2:0] S_RST_REL = 3'd2;
  localparam logic [2:0] S_SLOT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] CMD_RST = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_RD  = 2'b10;

  if (!(T_LOW1 < T_MSR && T_MSR < T_LOW0 && T_LOW0 < T_SLOT && T_MSP < T_RSTH))
  begin : g_bad_timing
    $error("onewire_byte_master: illegal slot/reset timing parameters");
  end

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [1:0]    cmd_q;
  logic [7:0]    wdata_q;
  logic [7:0]    rdata_q;
  logic [7:0]    crc_q;
  logic          pres_q;
  logic [1:0]    sync;
  logic [CW-1:0] low_len;
  logic          drive_low;
  logic          b;

  // Idle bus reads high, so the synchroniser resets to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], port};
  end

  assign b = sync[1];

  // Reads drive a write-1 slot; the slave stretches the low for a 0.
  always_comb begin
    low_len   = (cmd_q == CMD_RD || wdata_q[idx]) ? C_LOW1 : C_LOW0;
    drive_low = (state == S_RST_LOW) || (state == S_SLOT && cnt < low_len);
  end

  assign port = drive_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      cmd_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      crc_q   <= '0;
      pres_q  <= 1'b0;
    end else begin
      cnt <= cnt + CW'(1);
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (bus.crc_clr) crc_q <= '0;
          if (bus.cmd_valid) begin
            cmd_q   <= bus.cmd;
            wdata_q <= bus.wdata;
            idx     <= '0;
            case (bus.cmd)
              CMD_RST:        state <= S_RST_LOW;
              CMD_WR, CMD_RD: state <= S_SLOT;
              default:        state <= S_DONE;
            endcase
          end
        end
        S_RST_LOW: begin
          if (cnt == C_RSTL_END) begin
            cnt   <= '0;
            state <= S_RST_REL;
          end
        end
        S_RST_REL: begin
          if (cnt == C_MSP) pres_q <= ~b;
          if (cnt == C_RSTH_END) begin
            crc_q <= '0;
            state <= S_DONE;
          end
        end
        S_SLOT: begin
          if (cnt == C_MSR) begin
            rdata_q[idx] <= b;
            crc_q        <= {1'b0, crc_q[7:1]} ^ ((crc_q[0] ^ b) ? 8'h8C : 8'h00);
          end
          if (cnt == C_BIT_END) begin
            cnt <= '0;
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.rsp_valid = (state == S_DONE);
  assign bus.rdata     = rdata_q;
  assign bus.presence  = pres_q;
  assign bus.crc       = crc_q;
endmodule

// File: tb/tb_onewire_byte_master.sv
// Bench for onewire_byte_master: slave model on DQ, command-level reference
// model checked every cycle, plus hand-computed expectations.
module tb_onewire_byte_master;
  localparam int T_RSTL = 480, T_RSTH = 480, T_MSP = 70, T_LOW0 = 60;
  localparam int T_LOW1 = 6, T_MSR = 13, T_SLOT = 70, T_REC = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic slv_low = 1'b0;
  wire  port;

  onewire_byte_master_if bus();

  onewire_byte_master #(
    .T_RSTL(T_RSTL), .T_RSTH(T_RSTH), .T_MSP(T_MSP), .T_LOW0(T_LOW0),
    .T_LOW1(T_LOW1), .T_MSR(T_MSR), .T_SLOT(T_SLOT), .T_REC(T_REC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .port (port)
  );

  assign port = slv_low ? 1'b0 : 1'bz;
  pullup (port);

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 8'h8C) : (r >> 1);
    return r;
  endfunction

  // Slave model: records master low-pulse widths, answers presence, and
  // holds the line low during read slots that carry a 0.
  logic       slv_rd  = 1'b0;
  logic       pres_en = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  int         wq[$];

  initial begin
    int  sbit;
    longint t0;
    int  w;
    sbit = 0;
    forever begin
      @(negedge port);
      t0 = $time;
      if (slv_rd) begin
        if (!rd_byte[sbit]) begin
          slv_low = 1'b1;
          repeat (30) @(posedge clk);
          slv_low = 1'b0;
        end
        sbit = (sbit + 1) % 8;
      end else begin
        @(posedge port);
        w = int'(($time - t0) / 10);
        wq.push_back(w);
        if (pres_en && w > 200) begin
          repeat (30) @(posedge clk);
          slv_low = 1'b1;
          repeat (100) @(posedge clk);
          slv_low = 1'b0;
        end
      end
    end
  end

  // Reference model: expected command latency and end-of-command results.
  int         req_seq = 0, clr_seq = 0, rst_seq = 0;
  int         req_L = 1;
  logic [7:0] req_rdata = 8'h00, req_crc = 8'h00;
  logic       req_pres = 1'b0;
  logic [7:0] m_rdata = 8'h00, m_crc = 8'h00;
  logic       m_pres = 1'b0;
  logic       chk_en = 1'b0;

  initial begin
    int   idx, s_req, s_clr, s_rst;
    logic pend;
    idx = 0; s_req = 0; s_clr = 0; s_rst = 0; pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_seq != s_rst) begin
        s_rst = rst_seq; pend = 1'b0;
        m_rdata = 8'h00; m_pres = 1'b0; m_crc = 8'h00;
      end
      if (clr_seq != s_clr) begin s_clr = clr_seq; m_crc = 8'h00; end
      if (req_seq != s_req) begin s_req = req_seq; pend = 1'b1; idx = 0; end
      if (pend) idx++;
      if (chk_en) begin
        chk1("rsp_valid", bus.rsp_valid, pend && idx == req_L);
        chk1("busy", bus.busy, pend);
        chk1("cmd_ready", bus.cmd_ready, !pend);
      end
      if (pend && idx == req_L) begin
        m_rdata = req_rdata; m_pres = req_pres; m_crc = req_crc; pend = 1'b0;
      end
      if (chk_en && !pend) begin
        chk8("rdata", bus.rdata, m_rdata);
        chk1("presence", bus.presence, m_pres);
        chk8("crc", bus.crc, m_crc);
      end
    end
  end

  task automatic run_cmd(input logic [1:0] c, input logic [7:0] wd, input logic clr,
                         input logic [7:0] rdb, input int exp_lat, input logic busy_clr);
    logic [7:0] s;
    int   n;
    logic got;
    @(negedge clk); #1;
    s = clr ? 8'h00 : m_crc;
    req_rdata = m_rdata; req_pres = m_pres; req_crc = s;
    case (c)
      2'b00: begin req_L = T_RSTL + T_RSTH + 1; req_pres = pres_en; req_crc = 8'h00; end
      2'b01: begin req_L = 8 * (T_SLOT + T_REC) + 1; req_rdata = wd; req_crc = crc8(s, wd); end
      2'b10: begin req_L = 8 * (T_SLOT + T_REC) + 1; req_rdata = rdb; req_crc = crc8(s, rdb); end
      default: req_L = 1;
    endcase
    rd_byte = rdb;
    slv_rd  = (c == 2'b10);
    bus.cmd_valid = 1'b1; bus.cmd = c; bus.wdata = wd; bus.crc_clr = clr;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.crc_clr = 1'b0;
    req_seq++;
    n = 0; got = 1'b0;
    while (!got && n < 2000) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid) got = 1'b1;
      if (busy_clr) bus.crc_clr = (n == 100);
    end
    bus.crc_clr = 1'b0;
    if (!got) chki("rsp_timeout", n, exp_lat);
    else      chki("latency", n, exp_lat);
  endtask

  task automatic idle_clr();
    @(negedge clk); #1 bus.crc_clr = 1'b1;
    @(posedge clk); #1 bus.crc_clr = 1'b0;
    clr_seq++;
    @(negedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int ew[8];
    logic [7:0] rom[7];
    ew  = '{60, 60, 6, 6, 60, 60, 6, 6};
    rom = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00};
    bus.cmd_valid = 1'b0; bus.cmd = 2'b00; bus.wdata = 8'h00; bus.crc_clr = 1'b0;

    // reset values
    #23;
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk8("rst_rdata", bus.rdata, 8'h00);
    chk1("rst_presence", bus.presence, 1'b0);
    chk8("rst_crc", bus.crc, 8'h00);
    chk1("rst_port", port, 1'b1);
    @(negedge clk); #2 reset = 1'b1;
    chk_en = 1'b1;

    // reset with slave present
    pres_en = 1'b1; base = wq.size();
    run_cmd(2'b00, 8'h00, 1'b0, 8'h00, 961, 1'b0);
    chki("rst_pulse_count", wq.size() - base, 1);
    if (wq.size() > base) chki("rst_pulse_width", wq[base], 480);
    chk1("presence_yes", bus.presence, 1'b1);
    chk8("rst_crc_zero", bus.crc, 8'h00);

    // reset with no slave
    pres_en = 1'b0;
    run_cmd(2'b00, 8'h00, 1'b0, 8'h00, 961, 1'b0);
    chk1("presence_no", bus.presence, 1'b0);

    // write CC: slot widths LSB first
    base = wq.size();
    run_cmd(2'b01, 8'hCC, 1'b0, 8'h00, 601, 1'b0);
    chki("wr_pulse_count", wq.size() - base, 8);
    for (int i = 0; i < 8; i++)
      if (wq.size() > base + i) chki($sformatf("wr_pulse_width_%0d", i), wq[base + i], ew[i]);
    chk8("wr_rdata", bus.rdata, 8'hCC);

    // reserved command back-to-back: no bus activity, results unchanged
    base = wq.size();
    run_cmd(2'b11, 8'h55, 1'b0, 8'h00, 1, 1'b0);
    chki("rsv_no_bus", wq.size() - base, 0);
    chk8("rsv_rdata", bus.rdata, 8'hCC);

    // ROM bytes; first read carries crc_clr with cmd_valid
    for (int i = 0; i < 7; i++) begin
      run_cmd(2'b10, 8'h00, i == 0, rom[i], 601, 1'b0);
      chk8($sformatf("rd_rdata_%0d", i), bus.rdata, rom[i]);
    end
    chk8("rom_crc", bus.crc, 8'hA2);
    run_cmd(2'b10, 8'h00, 1'b0, 8'hA2, 601, 1'b0);
    chk8("rom_crc_final", bus.crc, 8'h00);

    // crc_clr while busy is ignored
    run_cmd(2'b01, 8'h3C, 1'b0, 8'h00, 601, 1'b1);
    chk8("wr3c_rdata", bus.rdata, 8'h3C);

    // crc_clr in idle
    idle_clr();
    chk8("idle_clr_crc", bus.crc, 8'h00);

    // async reset mid-slot while the master holds the line low
    slv_rd = 1'b0;
    @(negedge clk); #1;
    req_rdata = m_rdata; req_pres = m_pres; req_crc = m_crc; req_L = 601;
    bus.cmd_valid = 1'b1; bus.cmd = 2'b01; bus.wdata = 8'h00;
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    req_seq++;
    repeat (20) @(negedge clk);
    chk1("abort_port_low", port, 1'b0);
    #2 chk_en = 1'b0; reset = 1'b0;
    #1;
    chk1("abort_port", port, 1'b1);
    chk1("abort_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("abort_busy", bus.busy, 1'b0);
    chk1("abort_rsp_valid", bus.rsp_valid, 1'b0);
    chk8("abort_rdata", bus.rdata, 8'h00);
    chk8("abort_crc", bus.crc, 8'h00);
    rst_seq++;
    @(negedge clk); #2 reset = 1'b1;
    chk_en = 1'b1;
    pres_en = 1'b1;
    run_cmd(2'b00, 8'h00, 1'b0, 8'h00, 961, 1'b0);
    chk1("post_abort_presence", bus.presence, 1'b1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/onewire_byte_master.md
# onewire_byte_master

Parametrised 1-Wire bus master engine, the successor to the fixed-sequence 44h/BEh master. It executes host-issued commands (reset/presence, write byte, read byte) through a valid/ready command port. All slot timing is set by parameters, so it runs at any clock frequency. The bus is driven open-drain. A Dallas CRC-8 is kept over every bit moved, and the block sits between a sequencing controller and the DQ pad.

## Interface
- T_RSTL, 48000: reset pulse low time, cycles (480 µs at 100 MHz)
- T_RSTH, 48000: release time after reset pulse, cycles
- T_MSP, 7000: presence sample point, cycles after release
- T_LOW0, 6000: low time for a write-0 slot
- T_LOW1, 600: low time for write-1 and read slots
- T_MSR, 1300: read sample point, cycles after slot start
- T_SLOT, 7000: slot length, cycles
- T_REC, 500: recovery (released) time after each slot
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd  in  2  00 = reset/presence, 01 = write byte, 10 = read byte, 11 = reserved
- wdata  in  8  byte to write, captured on accept
- crc_clr  in  1  synchronous clear of crc; ignored while busy
- rsp_valid  out  1  one-cycle pulse at command completion
- rdata  out  8  bits sampled in the last byte command, LSB first
- presence  out  1  1 = presence pulse detected by the last reset command
- crc  out  8  running CRC-8 over sampled bits
- busy  out  1  high while not IDLE
- port  inout  1  1-Wire DQ; the block drives only 0 or z

## Operation
- Reset (reset low): state IDLE, counter 0, port = z, cmd_ready = 1, rsp_valid = 0, rdata = 0, presence = 0, crc = 0, busy = 0.
  - Effect is immediate. A slot in progress is abandoned and the bus is released.
- port input passes through a 2-flop synchroniser. All samples use the synchronised value.
- States: IDLE, RST_LOW, RST_REL, SLOT, DONE.
- Accept: cmd_valid & cmd_ready in IDLE. Capture cmd and wdata, and clear the bit index.
  - cmd 11 goes directly to DONE with no bus activity; rdata, presence and crc are unchanged.
- RST_LOW: drive 0 for T_RSTL cycles, then go to RST_REL.
- RST_REL: port = z for T_RSTH cycles.
  - At count T_MSP: presence <= ~synchronised port.
  - At end of T_RSTH: crc <= 0, then go to DONE.
- SLOT: one slot per bit, bit index 0..7, LSB first.
  - Drive 0 for T_LOW0 cycles if writing 0, or T_LOW1 cycles if writing 1 or reading; release after that.
  - At count T_MSR: sample b; rdata[idx] <= b; crc <= (crc>>1) ^ (crc[0]^b ? 8'h8C : 8'h00).
  - Slot ends at T_SLOT + T_REC. After bit 7, go to DONE; otherwise idx+1 and stay in SLOT.
- Write commands read back every bit: rdata equals wdata on a healthy bus. A mismatch indicates a bus fault; the block does not act on it.
- DONE: rsp_valid = 1 for one cycle, then IDLE.
- crc_clr in IDLE: crc <= 0. If crc_clr and cmd_valid are both high in the same cycle, the clear is applied first and the command is still accepted.
- Counter width: $clog2(max(T_RSTL, T_RSTH, T_SLOT + T_REC) + 1). The counter never wraps within a state.
- Parameter legality, checked by elaboration assertion:
  - T_LOW1 < T_MSR < T_LOW0 < T_SLOT
  - T_MSP < T_RSTH

## Timing
- Bus goes low on the first clk edge after accept.
- Reset command: accept to rsp_valid = T_RSTL + T_RSTH + 1 cycles.
- Byte command: accept to rsp_valid = 8·(T_SLOT + T_REC) + 1 cycles.
- Reserved command: rsp_valid on the cycle after accept.
- Sample instants lag the pin by 2 cycles of synchroniser latency. Parameters are specified at the pin.
- cmd_ready returns high in the cycle after rsp_valid. Back-to-back commands are accepted in that cycle.

## Test plan
- Reset with a bench slave pulling low 30–150 µs after release -> port low for exactly 48000 cycles, presence = 1, crc = 0, rsp_valid at cycle 96001.
- Reset with no slave (pull-up only) -> presence = 0, same latency.
- Write 8'hCC -> low-pulse widths, LSB first: 0,0,1,1,0,0,1,1 -> 6000,6000,600,600,6000,6000,600,600 cycles; rdata = 8'hCC; rsp_valid at 8·7500+1.
- Read 7 bytes from the slave model: 02 1C B8 01 00 00 00 -> crc = 8'hA2; reading an 8th byte A2 -> crc = 8'h00.
- Async reset asserted mid-slot while port is low -> port = z in the same cycle and all outputs at reset values; a following reset command completes normally.
- crc_clr pulsed together with cmd_valid (read) in IDLE -> crc cleared, command accepted, crc then reflects only the new byte.
